// File: rtl/rv32_pkg.sv
// rv32_pkg: shared definitions for the RV32I front end.
//   - XLEN / ILEN data widths
//   - fetch_state_e: fetch FSM state encoding
//   - fetch_entry_t: {pc, inst} entry held in the instruction queue
//   - RV_NOP: canonical NOP (addi x0, x0, 0)
//   - word_align / pc_plus4 helpers for PC arithmetic
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    REQ_STALE  = 3'd2,
    WAIT       = 3'd3,
    WAIT_STALE = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte offset so fetches always land on a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  // Sequential PC; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of {pc, inst} fetch entries.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   i_push        write i_push_data at the tail
//   i_push_data   entry to enqueue
//   i_pop         drop the head entry (ignored when empty)
//   i_flush       empty the queue; overrides a same-cycle push or pop
//   o_count       number of valid entries (0..DEPTH)
//   o_head        entry at the head (contents undefined when o_count==0)
module fetch_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty  = (r_count == {CW{1'b0}});
  assign w_full   = (r_count == FULL_COUNT);
  assign w_pop_ok = i_pop & ~w_empty;
  // When full, a push is only legal alongside a pop (count stays at DEPTH).
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^AW.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head never exposes X.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the PC, issues one word read at a time to instruction memory, queues
// returned words and hands {inst, pc, pc+4} to decode. Redirects flush the
// queue and mark any pending/in-flight request stale so its data is dropped.
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   imem_req/imem_addr           registered read request, address held until accepted
//   imem_ready                   memory accepts the request this cycle
//   imem_rvalid/imem_rdata       one in-order response per accepted request
//   inst_valid/inst/inst_pc/inst_nextpc  queue head to decode (zero when empty)
//   inst_ready                   decode consumes the head
//   redirect_valid/redirect_pc   taken branch/jump target
//   misalign_err                 one-cycle pulse after a redirect with pc[1:0]!=0
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_nextpc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_next;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] w_req_addr_next;
  logic            r_imem_req;
  logic            r_misalign;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_after;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_inst_valid;
  logic            w_space_idle;
  logic            w_space_after_push;
  logic [XLEN-1:0] w_redirect_tgt;
  logic [XLEN-1:0] w_pc_base;

  assign w_inst_valid   = (w_count != {CW{1'b0}});
  assign w_pop          = inst_ready & w_inst_valid;
  assign w_redirect_tgt = word_align(redirect_pc);
  // Address the next request would use: a redirect target overrides fetch_pc.
  assign w_pc_base      = redirect_valid ? w_redirect_tgt : r_fetch_pc;
  assign w_space_idle   = (w_count < DEPTH_C);
  // Occupancy after this cycle's push, crediting a same-cycle pop.
  assign w_count_after      = w_count + CW'(1) - CW'(w_pop);
  assign w_space_after_push = (w_count_after < DEPTH_C);
  assign w_push_entry       = '{pc: r_req_addr, inst: imem_rdata};
  assign w_flush            = redirect_valid;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK         (CLK),
    .RST         (RST),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // Next-state, PC and push decisions; redirect takes priority everywhere.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    w_push          = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect_valid) begin
          w_state_next    = REQ;
          w_fetch_pc_next = w_redirect_tgt;
          w_req_addr_next = w_redirect_tgt;
        end else if (w_space_idle) begin
          w_state_next    = REQ;
          w_req_addr_next = r_fetch_pc;
        end else begin
          w_state_next    = IDLE;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          w_fetch_pc_next = w_redirect_tgt;
          w_state_next    = imem_ready ? WAIT_STALE : REQ_STALE;
        end else if (imem_ready) begin
          w_state_next    = WAIT;
          w_fetch_pc_next = pc_plus4(r_fetch_pc);
        end else begin
          w_state_next    = REQ;
        end
      end
      REQ_STALE: begin
        // fetch_pc already holds the redirect target; only a newer redirect moves it.
        w_fetch_pc_next = w_pc_base;
        if (imem_ready) begin
          w_state_next = WAIT_STALE;
        end else begin
          w_state_next = REQ_STALE;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_fetch_pc_next = w_redirect_tgt;
          if (imem_rvalid) begin
            w_state_next    = REQ;
            w_req_addr_next = w_redirect_tgt;
          end else begin
            w_state_next    = WAIT_STALE;
          end
        end else if (imem_rvalid) begin
          w_push = 1'b1;
          if (w_space_after_push) begin
            w_state_next    = REQ;
            w_req_addr_next = r_fetch_pc;
          end else begin
            w_state_next    = IDLE;
          end
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT_STALE: begin
        w_fetch_pc_next = w_pc_base;
        if (imem_rvalid) begin
          if (redirect_valid || w_space_idle) begin
            w_state_next    = REQ;
            w_req_addr_next = w_pc_base;
          end else begin
            w_state_next    = IDLE;
          end
        end else begin
          w_state_next = WAIT_STALE;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_fetch_pc_next = RESET_PC;
        w_req_addr_next = RESET_PC;
      end
    endcase
  end

  // FSM, PC and registered request/error outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_imem_req <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
      r_imem_req <= (w_state_next == REQ) || (w_state_next == REQ_STALE);
      r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_req_addr;
  assign misalign_err = r_misalign;
  assign inst_valid   = w_inst_valid;
  // Head fields read zero whenever the queue is empty, including after reset.
  assign inst         = w_inst_valid ? w_head.inst : {ILEN{1'b0}};
  assign inst_pc      = w_inst_valid ? w_head.pc : {XLEN{1'b0}};
  assign inst_nextpc  = w_inst_valid ? pc_plus4(w_head.pc) : {XLEN{1'b0}};

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the single-cycle RV32I core datapath.
- Owns the PC and issues word reads to instruction memory over a req/ready + rvalid handshake.
- Buffers returned words in a small queue and presents instruction, PC and PC+4 to the core's decode with valid/ready.
- Accepts branch/jump redirects from the core, flushes stale work and squashes in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- DEPTH, 2: instruction queue entries; power of two, 2..8.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word-aligned fetch address; held stable while imem_req=1 and not accepted.
- imem_ready  in  1  memory accepts the request this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; exactly one per accepted request, in order, at least 1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst  out  32  queue head instruction.
- inst_pc  out  32  PC of the head instruction.
- inst_nextpc  out  32  inst_pc + 4, modulo 2^32.
- inst_ready  in  1  core consumes the head this cycle.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch target.
- misalign_err  out  1  one-cycle pulse; redirect_pc[1:0] was nonzero.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, fetch_pc=RESET_PC, queue empty.
  - imem_req=0, inst_valid=0, misalign_err=0.
  - inst, inst_pc and inst_nextpc read 0.
- Outstanding limit: at most one request is pending or in flight.
- States:
  - IDLE: no request pending or in flight.
  - REQ: request asserted, not yet accepted.
  - REQ_STALE: REQ, but the request has been invalidated by a redirect.
  - WAIT: request accepted, response not yet received.
  - WAIT_STALE: WAIT, but the response will be discarded.
- IDLE -> REQ: when queue count + 0 < DEPTH.
  - imem_req is registered, so it asserts in the cycle after the decision.
  - First request after RST falls: imem_req=1, imem_addr=RESET_PC in the first cycle after the first post-reset edge.
- REQ -> WAIT: on imem_ready; fetch_pc += 4.
- WAIT -> IDLE or REQ: on imem_rvalid.
  - {imem_rdata, addr} is pushed into the queue at that edge.
  - inst_valid rises in the next cycle.
  - The next request is issued back-to-back if space remains after the push; a pop in the same cycle counts as freeing space.
- Queue behaviour:
  - Push and pop in the same cycle leave the count unchanged, including when full.
  - A pop with an empty queue is ignored.
  - A push is never issued when the queue is full; this is guaranteed by the outstanding-limit rule.
- Redirect (redirect_valid=1 at an edge); highest priority:
  - Queue is flushed, including any same-cycle push.
  - inst_valid=0 in the next cycle.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - REQ -> REQ_STALE: imem_addr stays stable until accepted, then the state goes to WAIT_STALE.
  - WAIT -> WAIT_STALE.
  - IDLE: a new request to the target is issued next cycle.
  - A redirect in the same cycle as an imem_ready handshake goes to WAIT_STALE.
  - A redirect in the same cycle as imem_rvalid drops that response and goes to IDLE (or REQ).
  - A second redirect while already stale only updates fetch_pc.
- WAIT_STALE on imem_rvalid: data is discarded and the state goes to IDLE (or REQ). The core never observes stale words.
- misalign_err pulses one cycle after a redirect with redirect_pc[1:0] != 0; the fetch proceeds at the aligned address.
- inst_ready is only meaningful when inst_valid=1.
- Reset mid-operation: everything returns to reset values immediately. A late imem_rvalid arriving after reset release with no request issued is ignored.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.

Decomposition:
- Shared package rv32_pkg:
  - XLEN=32, ILEN=32.
  - Fetch state encoding: IDLE, REQ, REQ_STALE, WAIT, WAIT_STALE.
  - RV_NOP=32'h0000_0013.
- Sub-module fetch_queue (DEPTH x 64-bit {pc, inst} circular buffer):
  - Ports: push, pop, flush, count, head outputs.
  - Pointers are log2(DEPTH) bits wide and wrap; count is log2(DEPTH)+1 bits.

Test Plan:
- Reset then straight-line fetch:
  - Stimulus: imem_ready=1 always, rvalid 1 cycle later, inst_ready=1.
  - Response: addresses 0,4,8,12 issued; inst_pc/inst_nextpc pairs (0,4), (4,8), (8,12) in order; imem_rdata passed through unchanged.
- Backpressure:
  - Stimulus: inst_ready=0 with DEPTH=2.
  - Response: exactly 2 words queued, imem_req stays 0.
  - Then raise inst_ready for one cycle: exactly one new request (addr 8) is issued.
- Redirect while in WAIT:
  - Stimulus: redirect_pc=32'h100 while the request for 0x8 is in flight.
  - Response: the 0x8 word is dropped; the next inst_pc seen is 0x100; no inst_valid between.
- Redirect coinciding with rvalid and with imem_ready:
  - Both words are discarded.
  - The following fetch address is the target.
  - The queue is empty the next cycle.
- Misaligned redirect:
  - Stimulus: redirect_pc=32'h206.
  - Response: misalign_err=1 for one cycle; the next imem_addr is 0x204.
- Async reset mid-WAIT:
  - Stimulus: RST pulsed between edges.
  - Response: outputs 0 immediately; after release, fetch restarts at RESET_PC; no stale inst_valid.
